// File: rtl/nibble_pkg.sv
// Shared types and sizing helpers for the nibble packer slice.
package nibble_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, FILL, LAST, STALL} state_t;

    function automatic int len_w(input int nibbles);
        return $clog2(nibbles) + 1;
    endfunction
endpackage

// File: rtl/nibble_packer_if.sv
// Nibble input stream plus packed-word valid/ready output of the packer.
interface nibble_packer_if
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 4
) ();
    localparam int LW = len_w(NIBBLES);

    logic                        in_valid;
    logic                        in_ready;
    logic [NIBBLE_W-1:0]         q;
    logic                        rco;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [NIBBLE_W*NIBBLES-1:0] word;
    logic [NIBBLES-1:0]          carry;
    logic [LW-1:0]               len;
    logic                        ovf;

    modport slave (
        input  in_valid, q, rco, flush, out_ready,
        output in_ready, out_valid, word, carry, len, ovf
    );

    modport master (
        output in_valid, q, rco, flush, out_ready,
        input  in_ready, out_valid, word, carry, len, ovf
    );
endinterface

// File: rtl/word_fifo2.sv
// Two-entry FIFO whose head register drives the output directly.
module word_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] tail;
    logic [1:0]    cnt;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 2'd0;
            dout <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: if (!full) begin
                    if (empty) dout <= din;
                    else       tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: if (!empty) begin
                    dout <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (full) begin
                        dout <= tail;
                        tail <= din;
                    end else begin
                        dout <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/nibble_packer.sv
// Packs successive adder result nibbles and carries into wide words behind a 2-entry queue.
module nibble_packer
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    nibble_packer_if.slave   bus
);
    localparam int LW = len_w(NIBBLES);
    localparam int WW = NIBBLE_W * NIBBLES;
    localparam int DW = WW + NIBBLES + LW;
    localparam logic [LW-1:0] FULL_CNT = LW'(NIBBLES);
    localparam logic [LW-1:0] LAST_CNT = LW'(NIBBLES - 1);

    state_t             state, state_n;
    logic [LW-1:0]      count, cnt_a, count_n;
    logic [WW-1:0]      asm_word, word_a, word_n;
    logic [NIBBLES-1:0] asm_carry, carry_a, carry_n;
    logic               pend, pend_n, ovf;
    logic               acc, pop, push, full, empty, full_n;
    logic [DW-1:0]      din, dout;

    assign pop          = !empty && bus.out_ready;
    assign bus.in_ready = (state != STALL) || pop;
    assign acc          = bus.in_valid && bus.in_ready;

    always_comb begin
        word_a  = asm_word;
        carry_a = asm_carry;
        cnt_a   = count;
        if (acc) begin
            for (int k = 0; k < NIBBLES; k++) begin
                if (count == LW'(k)) begin
                    word_a[k*NIBBLE_W +: NIBBLE_W] = bus.q;
                    carry_a[k]                     = bus.rco;
                end
            end
            cnt_a = count + LW'(1);
        end

        din     = {word_a, carry_a, cnt_a};
        push    = 1'b0;
        count_n = cnt_a;
        word_n  = word_a;
        carry_n = carry_a;
        pend_n  = pend;
        // A completed word always wins; a flush arriving with it has nothing left to emit.
        if (cnt_a == FULL_CNT) begin
            push    = 1'b1;
            count_n = '0;
            word_n  = '0;
            carry_n = '0;
            pend_n  = 1'b0;
        end else if (bus.flush || pend) begin
            if (cnt_a == '0) begin
                pend_n = 1'b0;
            end else if (!full || pop) begin
                push    = 1'b1;
                count_n = '0;
                word_n  = '0;
                carry_n = '0;
                pend_n  = 1'b0;
            end else begin
                pend_n = 1'b1;
            end
        end

        if (push && !pop)      full_n = !empty;
        else if (pop && !push) full_n = 1'b0;
        else                   full_n = full;

        if (count_n == '0)                                 state_n = IDLE;
        else if (full_n && (count_n == LAST_CNT || pend_n)) state_n = STALL;
        else if (count_n == LAST_CNT)                      state_n = LAST;
        else                                               state_n = FILL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            asm_word  <= '0;
            asm_carry <= '0;
            pend      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            asm_word  <= word_n;
            asm_carry <= carry_n;
            pend      <= pend_n;
            ovf       <= ovf || (bus.in_valid && !bus.in_ready);
        end
    end

    word_fifo2 #(.DW(DW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_valid = !empty;
    assign {bus.word, bus.carry, bus.len} = dout;
    assign bus.ovf = ovf;
endmodule

// File: tb/tb_nibble_packer.sv
// Directed scenarios plus a randomized run checked against a queue-based packing model.
module tb_nibble_packer;
    import nibble_pkg::*;

    localparam int N  = 4;
    localparam int LW = len_w(N);
    localparam int WW = NIBBLE_W * N;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nibble_packer_if #(.NIBBLES(N)) bus ();
    nibble_packer #(.NIBBLES(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [WW-1:0] w;
        logic [N-1:0]  c;
        logic [LW-1:0] l;
    } word_t;

    word_t      mq[$];
    logic [4:0] nib[$];
    bit         fpend, m_ovf;
    int         checks = 0, fails = 0;
    logic       obs_ready, exp_ready;

    task automatic emit();
        word_t e;
        e.w = '0;
        e.c = '0;
        for (int k = 0; k < nib.size(); k++) begin
            e.w[k*4 +: 4] = nib[k][3:0];
            e.c[k]        = nib[k][4];
        end
        e.l = LW'(nib.size());
        mq.push_back(e);
        nib.delete();
    endtask

    // One clock: drive inputs, sample in_ready mid-cycle, advance the model, land 1 after the edge.
    task automatic cycle(input bit v, input logic [3:0] qv, input bit r, input bit f, input bit ordy);
        bit pop, acc;
        bus.in_valid = v; bus.q = qv; bus.rco = r; bus.flush = f; bus.out_ready = ordy;
        @(negedge clk);
        obs_ready = bus.in_ready;
        pop = (mq.size() > 0) && ordy;
        exp_ready = !((mq.size() == 2) && (nib.size() == N-1 || fpend)) || pop;
        acc = v && exp_ready;
        if (v && !exp_ready) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (acc) nib.push_back({r, qv});
        if (nib.size() == N) begin
            emit();
            fpend = 1'b0;
        end else if (f || fpend) begin
            if (nib.size() == 0) fpend = 1'b0;
            else if (mq.size() < 2) begin emit(); fpend = 1'b0; end
            else fpend = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        bus.in_valid = 0; bus.q = 0; bus.rco = 0; bus.flush = 0; bus.out_ready = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete(); nib.delete(); fpend = 0; m_ovf = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.word !== 16'h0) begin fails++; $display("FAIL reset_word got %h want 0", bus.word); end
        checks++; if (bus.carry !== 4'h0) begin fails++; $display("FAIL reset_carry got %b want 0", bus.carry); end
        checks++; if (bus.len !== 3'd0) begin fails++; $display("FAIL reset_len got %0d want 0", bus.len); end
        checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) cycle(1, 4'(i+1), 1'(i%2), 0, 1);
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.word !== 16'h4321) begin fails++; $display("FAIL basic_word got %h want 4321", bus.word); end
        checks++; if (bus.carry !== 4'b1010) begin fails++; $display("FAIL basic_carry got %b want 1010", bus.carry); end
        checks++; if (bus.len !== 3'd4) begin fails++; $display("FAIL basic_len got %0d want 4", bus.len); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        cycle(1, 4'hA, 0, 0, 1);
        cycle(1, 4'hB, 0, 0, 1);
        cycle(1, 4'hC, 0, 1, 1);
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.word !== 16'h0CBA) begin fails++; $display("FAIL flush_word got %h want 0cba", bus.word); end
        checks++; if (bus.len !== 3'd3) begin fails++; $display("FAIL flush_len got %0d want 3", bus.len); end
        checks++; if (bus.carry !== 4'b0000) begin fails++; $display("FAIL flush_carry got %b want 0000", bus.carry); end
        cycle(0, 0, 0, 1, 1);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty_a got %b want 0", bus.out_valid); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty_b got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 12; i++) begin
            cycle(1, 4'(i), 0, 0, 0);
            checks++; if (obs_ready !== (i < 11)) begin fails++; $display("FAIL bp_in_ready nibble %0d got %b want %b", i, obs_ready, i < 11); end
        end
        checks++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL bp_ovf got %b want 1", bus.ovf); end
        checks++; if (bus.word !== 16'h3210) begin fails++; $display("FAIL bp_first got %h want 3210", bus.word); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.word !== 16'h7654) begin fails++; $display("FAIL bp_second got %h want 7654", bus.word); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b want 0", bus.out_valid); end
        cycle(1, 4'hC, 0, 0, 1);
        checks++; if (bus.word !== 16'hCA98) begin fails++; $display("FAIL bp_resume got %h want ca98", bus.word); end
        cycle(0, 0, 0, 0, 1);
        apply_reset();
        checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL bp_ovf_clear got %b want 0", bus.ovf); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 11; i++) cycle(1, 4'(i), 0, 0, 0);
        cycle(1, 4'h5, 1, 0, 1);
        checks++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL simul_ready got %b want 1", obs_ready); end
        checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL simul_ovf got %b want 0", bus.ovf); end
        checks++; if (bus.word !== 16'h7654) begin fails++; $display("FAIL simul_head got %h want 7654", bus.word); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.word !== 16'h5A98 || bus.carry !== 4'b1000) begin fails++; $display("FAIL simul_tail got %h/%b want 5a98/1000", bus.word, bus.carry); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL simul_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 4'h1, 0, 0, 1);
        cycle(1, 4'h2, 0, 0, 1);
        apply_reset();
        checks++; if (bus.out_valid !== 1'b0 || bus.word !== 16'h0 || bus.len !== 3'd0 || bus.in_ready !== 1'b1)
            begin fails++; $display("FAIL rstmid_outputs got v=%b w=%h l=%0d r=%b want 0/0/0/1", bus.out_valid, bus.word, bus.len, bus.in_ready); end
        for (int i = 5; i <= 8; i++) cycle(1, 4'(i), 0, 0, 1);
        checks++; if (bus.word !== 16'h8765 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_word got %h v=%b want 8765 v=1", bus.word, bus.out_valid); end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) cycle(0, 0, 0, 0, 1);
            cycle(1, 4'(i+1), 1'(i%2), 0, 1);
        end
        checks++; if (bus.word !== 16'h4321 || bus.carry !== 4'b1010) begin fails++; $display("FAIL gaps_word got %h/%b want 4321/1010", bus.word, bus.carry); end
        checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL gaps_ovf got %b want 0", bus.ovf); end
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit ordy;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            ordy = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, ordy);
            checks++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL rand_in_ready cyc %0d got %b want %b", i, obs_ready, exp_ready); end
            checks++; if (bus.out_valid !== (mq.size() > 0)) begin fails++; $display("FAIL rand_valid cyc %0d got %b want %b", i, bus.out_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++;
                if (bus.word !== mq[0].w || bus.carry !== mq[0].c || bus.len !== mq[0].l) begin
                    fails++;
                    $display("FAIL rand_head cyc %0d got %h/%b/%0d want %h/%b/%0d", i, bus.word, bus.carry, bus.len, mq[0].w, mq[0].c, mq[0].l);
                end
            end
            checks++; if (bus.ovf !== m_ovf) begin fails++; $display("FAIL rand_ovf cyc %0d got %b want %b", i, bus.ovf, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_simul();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nibble_packer.md
# nibble_packer

Downstream stage of the 4-bit adder (`Sumador`). Collects successive 4-bit results `Q` and their carry `RCO` into wide words of NIBBLES nibbles and presents them on a valid/ready output with a 2-entry output queue. Gives the rest of the design a wide, flow-controlled result stream from the nibble-serial adder, and flags any result the adder produced while the packer could not accept it.

## Interface
- NIBBLES, 4, nibbles per packed word (2..8); WORD width = 4·NIBBLES
- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  Q/RCO hold a new adder result this cycle (the adder's ENB delayed one cycle by the integrating top)
- Q  in  4  adder result nibble
- RCO  in  1  adder carry-out for that nibble
- FLUSH  in  1  pulse: emit the partially filled word now
- IN_READY  out  1  a nibble presented this cycle will be accepted
- OUT_VALID  out  1  WORD/CARRY/LEN valid
- OUT_READY  in  1  consumer accepts the word this cycle
- WORD  out  4·NIBBLES  packed result, first nibble in bits [3:0]
- CARRY  out  NIBBLES  RCO of each nibble, bit k ↔ nibble k
- LEN  out  clog2(NIBBLES)+1  number of valid nibbles in WORD (1..NIBBLES)
- OVF  out  1  sticky: a nibble was offered while IN_READY=0

## Operation
- Accept when IN_VALID && IN_READY. Nibble k → assembly bits [4k+3:4k], RCO → carry bit k, count++.
- On the accept that makes count = NIBBLES, push {word, carry, LEN=NIBBLES} into the queue and clear count/assembly.
- FLUSH with count>0 (after applying a same-cycle accept) pushes the partial word. Unfilled nibbles and carry bits are 0. LEN = count. FLUSH with count=0 after the same-cycle accept does nothing.
- FSM states:
  - IDLE (count=0)
  - FILL (0<count<NIBBLES−1)
  - LAST (count=NIBBLES−1, queue has space)
  - STALL (count=NIBBLES−1 or FLUSH pending, queue full)
- IN_READY = 0 only in STALL with no same-cycle pop. IN_READY is combinational from OUT_READY: a pop in STALL frees a slot and allows the accept in the same cycle.
- FLUSH in STALL is held pending until a slot frees.
- IN_VALID && !IN_READY: the nibble is dropped and OVF is set. OVF stays set until RESET.
- Queue: 2 entries, FIFO order. Pop on OUT_VALID && OUT_READY. Simultaneous push and pop allowed in any occupancy, including full.
- Reset values: count=0, queue empty, OUT_VALID=0, WORD=0, CARRY=0, LEN=0, OVF=0, IN_READY=1, state IDLE, pending flush cleared.
- RESET mid-word discards the partial word and all queued words. There is no output for them.

## Timing
- Latency: a word is pushed on the edge that accepts its last nibble (or FLUSH). OUT_VALID rises on that edge, so the word is visible the following cycle.
- Throughput: one nibble per cycle sustained while OUT_READY holds high. Full queue plus one partial word absorbs 3·NIBBLES−1 nibbles of backpressure before STALL.
- Outputs are registered from the queue head. WORD/CARRY/LEN remain stable while OUT_VALID && !OUT_READY.
- IN_VALID=0 never changes count. Gaps between nibbles are allowed.

## Structure
- Package `nibble_pkg`:
  - NIBBLE_W=4
  - state enum {IDLE, FILL, LAST, STALL}
  - function for LEN width
- Sub-module `word_fifo2`: 2-entry synchronous FIFO with push/pop/full/empty, data width 5·NIBBLES+LEN width, same CLK/RESET.
- Packer FSM, assembly register and OVF live in `nibble_packer`.

## Test plan
- Basic packing: RESET, then OUT_READY=1 and Q=1,2,3,4 on consecutive cycles with RCO=0,1,0,1 → WORD=16'h4321, CARRY=4'b1010, LEN=4, OUT_VALID for one cycle, the cycle after the 4th nibble.
- Partial flush: 3 nibbles Q=A,B,C with FLUSH on the cycle of the 3rd nibble → WORD=16'h0CBA, LEN=3. FLUSH again with count=0 → no output.
- Backpressure: OUT_READY=0, stream 12 nibbles 0..B → IN_READY falls after nibble 10 (count=3, queue full). Nibbles 11 (value B) offered while stalled → OVF=1. Raise OUT_READY → words 16'h3210, 16'h7654 in order, then the partial word from nibbles 8,9,A resumes.
- Simultaneous pop/accept: queue full, count=3, OUT_READY=1 and IN_VALID in the same cycle → nibble accepted, no OVF, queue stays full, order preserved.
- Reset mid-word: 2 nibbles accepted, RESET for 1 cycle → all outputs at reset values. Next 4 nibbles 5,6,7,8 → WORD=16'h8765.
- Gaps: nibbles separated by 0–3 idle cycles → same WORD as the gapless case. OVF stays 0.
